// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared definitions for the VGA catch game: game state
//               encodings and default playfield geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Encodings are fixed so that software and the overlays can decode them.
    typedef enum logic [1:0] {
        ST_PAUSE = 2'b00,
        ST_IDLE  = 2'b01,
        ST_OVER  = 2'b10,
        ST_PLAY  = 2'b11
    } state_t;

    localparam int C_CATCH_W        = 48;   // catcher width in pixels
    localparam int C_DROP_W         = 48;   // drop width in pixels
    localparam int C_CATCHER_LINE_Y = 440;  // y row where drops land

endpackage
`default_nettype wire

// File: rtl/popcount.sv
`default_nettype none
// ============================================================================
// Module      : popcount
// Description : Purely combinational population count of an N-bit vector.
// Ports       : bits_i  - input vector
//               count_o - number of set bits in bits_i
// Revision    : 1.0 - initial release
// ============================================================================
module popcount
    import game_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic [N-1:0]     bits_i,
    output logic [CNT_W-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int k = 0; k < N; k++) begin
            count_o = count_o + CNT_W'(bits_i[k]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/catch_game_ctl.sv
`default_nettype none
// ============================================================================
// Module      : catch_game_ctl
// Description : Game control for the VGA catch game. Tracks game state,
//               score, lives and difficulty level for N_DROPS falling drops
//               against one catcher. All outputs are registered.
// Ports       : pclk, rst (async, active low)
//               frame_tick, start_btn, pause_btn, restart_btn - controls
//               catcher_x, drop_x, drop_land - geometry and landing strobes
//               state, score, lives, level, frame_cnt - game status
//               catch_pulse, miss_pulse - per-channel landing results
//               drops_run - enables the drop motion controllers
// Revision    : 1.0 - initial release
// ============================================================================
module catch_game_ctl
    import game_pkg::*;
#(
    parameter int N_DROPS    = 4,
    parameter int POS_W      = 12,
    parameter int SCORE_W    = 16,
    parameter int LIVES      = 3,
    parameter int CATCH_W    = C_CATCH_W,
    parameter int DROP_W     = C_DROP_W,
    parameter int LEVEL_STEP = 10
) (
    input  logic                       pclk,
    input  logic                       rst,
    input  logic                       frame_tick,
    input  logic                       start_btn,
    input  logic                       pause_btn,
    input  logic                       restart_btn,
    input  logic [POS_W-1:0]           catcher_x,
    input  logic [N_DROPS*POS_W-1:0]   drop_x,
    input  logic [N_DROPS-1:0]         drop_land,
    output logic [1:0]                 state,
    output logic [SCORE_W-1:0]         score,
    output logic [3:0]                 lives,
    output logic [3:0]                 level,
    output logic [N_DROPS-1:0]         catch_pulse,
    output logic [N_DROPS-1:0]         miss_pulse,
    output logic                       drops_run,
    output logic [15:0]                frame_cnt
);

    localparam int CNT_W = $clog2(N_DROPS + 1);
    // Holds the leftover points plus the largest single-cycle gain.
    localparam int PTS_W = $clog2(LEVEL_STEP + N_DROPS + 1);
    localparam logic [PTS_W-1:0] C_STEP       = PTS_W'(LEVEL_STEP);
    localparam logic [POS_W:0]   C_CATCH_SPAN = (POS_W+1)'(CATCH_W - 1);
    localparam logic [POS_W:0]   C_DROP_SPAN  = (POS_W+1)'(DROP_W - 1);

    state_t               state_q, state_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [3:0]           lives_q, lives_d;
    logic [3:0]           level_q, level_d;
    logic [PTS_W-1:0]     pts_q, pts_d;
    logic [15:0]          frame_q, frame_d;
    logic [N_DROPS-1:0]   catch_q, catch_d;
    logic [N_DROPS-1:0]   miss_q, miss_d;
    logic                 run_q, run_d;
    logic                 start_q, pause_q, restart_q;
    logic [N_DROPS-1:0]   land_q;
    // Low for the first cycle out of reset so a button held through reset
    // is absorbed into the history instead of firing.
    logic                 armed_q;

    logic                 w_start_e, w_pause_e, w_restart_e;
    logic [N_DROPS-1:0]   w_land_e, w_hit, w_caught, w_missed;
    logic [CNT_W-1:0]     w_n_caught, w_n_missed, w_gain;
    logic [SCORE_W:0]     w_score_sum;
    logic [SCORE_W-1:0]   w_score_sat;
    logic [3:0]           w_lives_after;
    logic [PTS_W-1:0]     w_pts_acc;
    logic [3:0]           w_lvl_acc;
    logic [POS_W:0]       w_cx;

    assign w_start_e   = start_btn   & ~start_q   & armed_q;
    assign w_pause_e   = pause_btn   & ~pause_q   & armed_q;
    assign w_restart_e = restart_btn & ~restart_q & armed_q;
    assign w_land_e    = drop_land & ~land_q;

    // Interval overlap test; one extra bit keeps the edge sums from wrapping.
    assign w_cx = {1'b0, catcher_x};
    for (genvar g = 0; g < N_DROPS; g++) begin : g_hit
        logic [POS_W:0] w_dx;
        assign w_dx     = {1'b0, drop_x[g*POS_W +: POS_W]};
        assign w_hit[g] = (w_cx <= w_dx + C_DROP_SPAN) &&
                          (w_dx <= w_cx + C_CATCH_SPAN);
    end

    assign w_caught = w_land_e & w_hit;
    assign w_missed = w_land_e & ~w_hit;

    popcount #(.N(N_DROPS), .CNT_W(CNT_W)) u_pc_catch (
        .bits_i  (w_caught),
        .count_o (w_n_caught)
    );

    popcount #(.N(N_DROPS), .CNT_W(CNT_W)) u_pc_miss (
        .bits_i  (w_missed),
        .count_o (w_n_missed)
    );

    assign w_score_sum   = {1'b0, score_q} + (SCORE_W+1)'(w_n_caught);
    assign w_score_sat   = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];
    // Points actually credited after saturation drive the level counter.
    assign w_gain        = CNT_W'(w_score_sat - score_q);
    assign w_lives_after = ({1'b0, lives_q} > 5'(w_n_missed)) ?
                           (lives_q - 4'(w_n_missed)) : 4'd0;

    // Modulo-LEVEL_STEP remainder; a gain may cross several step boundaries
    // when LEVEL_STEP is smaller than N_DROPS.
    always_comb begin
        w_pts_acc = pts_q + PTS_W'(w_gain);
        w_lvl_acc = level_q;
        for (int k = 0; k <= N_DROPS; k++) begin
            if (w_pts_acc >= C_STEP) begin
                w_pts_acc = w_pts_acc - C_STEP;
                if (w_lvl_acc != 4'd15) begin
                    w_lvl_acc = w_lvl_acc + 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        level_d = level_q;
        pts_d   = pts_q;
        frame_d = frame_q;
        catch_d = '0;
        miss_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (w_start_e) begin
                    state_d = ST_PLAY;
                    score_d = '0;
                    lives_d = 4'(LIVES);
                    level_d = 4'd0;
                    pts_d   = '0;
                    frame_d = 16'd0;
                end
            end
            ST_PLAY: begin
                catch_d = w_caught;
                miss_d  = w_missed;
                score_d = w_score_sat;
                lives_d = w_lives_after;
                level_d = w_lvl_acc;
                pts_d   = w_pts_acc;
                frame_d = frame_q + 16'(frame_tick);
                // Landings are scored before the pause; running out of
                // lives overrides a simultaneous pause.
                if (w_lives_after == 4'd0) begin
                    state_d = ST_OVER;
                end else if (w_pause_e) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (w_pause_e) begin
                    state_d = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (w_restart_e) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        run_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            score_q   <= '0;
            lives_q   <= 4'd0;
            level_q   <= 4'd0;
            pts_q     <= '0;
            frame_q   <= 16'd0;
            catch_q   <= '0;
            miss_q    <= '0;
            run_q     <= 1'b0;
            start_q   <= 1'b0;
            pause_q   <= 1'b0;
            restart_q <= 1'b0;
            land_q    <= '0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            level_q   <= level_d;
            pts_q     <= pts_d;
            frame_q   <= frame_d;
            catch_q   <= catch_d;
            miss_q    <= miss_d;
            run_q     <= run_d;
            start_q   <= start_btn;
            pause_q   <= pause_btn;
            restart_q <= restart_btn;
            land_q    <= drop_land;
            armed_q   <= 1'b1;
        end
    end

    assign state       = state_q;
    assign score       = score_q;
    assign lives       = lives_q;
    assign level       = level_q;
    assign catch_pulse = catch_q;
    assign miss_pulse  = miss_q;
    assign drops_run   = run_q;
    assign frame_cnt   = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_catch_game_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_catch_game_ctl
// Description : Self-checking bench for catch_game_ctl with a behavioural
//               game model compared every cycle plus literal checkpoints.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_catch_game_ctl;

    localparam int ND   = 4;
    localparam int PW   = 12;
    localparam int SMAX = 65535;
    localparam int CW   = 48;
    localparam int DW   = 48;
    localparam logic [1:0] S_IDLE  = 2'b01;
    localparam logic [1:0] S_PLAY  = 2'b11;
    localparam logic [1:0] S_PAUSE = 2'b00;
    localparam logic [1:0] S_OVER  = 2'b10;

    logic             pclk, rst, frame_tick, start_btn, pause_btn, restart_btn;
    logic [PW-1:0]    catcher_x;
    logic [ND*PW-1:0] drop_x;
    logic [ND-1:0]    drop_land;
    logic [1:0]       state;
    logic [15:0]      score;
    logic [3:0]       lives, level;
    logic [ND-1:0]    catch_pulse, miss_pulse;
    logic             drops_run;
    logic [15:0]      frame_cnt;

    catch_game_ctl dut (
        .pclk        (pclk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .start_btn   (start_btn),
        .pause_btn   (pause_btn),
        .restart_btn (restart_btn),
        .catcher_x   (catcher_x),
        .drop_x      (drop_x),
        .drop_land   (drop_land),
        .state       (state),
        .score       (score),
        .lives       (lives),
        .level       (level),
        .catch_pulse (catch_pulse),
        .miss_pulse  (miss_pulse),
        .drops_run   (drops_run),
        .frame_cnt   (frame_cnt)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state.
    logic [1:0]    m_state;
    int            m_score, m_lives, m_level, m_frame;
    logic [ND-1:0] m_cp, m_mp;
    bit            m_run;
    bit            h_start, h_pause, h_restart, m_live_cycle;
    logic [ND-1:0] h_land;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_score = 0; m_lives = 0; m_level = 0; m_frame = 0;
        m_cp = '0; m_mp = '0; m_run = 0;
        h_start = 0; h_pause = 0; h_restart = 0; h_land = '0; m_live_cycle = 0;
    endtask

    task automatic model_step();
        bit se, pe, re;
        logic [ND-1:0] le;
        int nc, nm, dx, cx;
        if (!rst) begin
            model_reset();
            return;
        end
        se = start_btn && !h_start && m_live_cycle;
        pe = pause_btn && !h_pause && m_live_cycle;
        re = restart_btn && !h_restart && m_live_cycle;
        le = drop_land & ~h_land;
        h_start = start_btn; h_pause = pause_btn; h_restart = restart_btn;
        h_land = drop_land; m_live_cycle = 1;
        m_cp = '0; m_mp = '0;
        case (m_state)
            S_IDLE: if (se) begin
                m_state = S_PLAY; m_score = 0; m_lives = 3; m_frame = 0;
            end
            S_PLAY: begin
                nc = 0; nm = 0; cx = int'(catcher_x);
                for (int i = 0; i < ND; i++) begin
                    if (le[i]) begin
                        dx = int'(drop_x[i*PW +: PW]);
                        if (cx <= dx + DW - 1 && dx <= cx + CW - 1) begin
                            nc++; m_cp[i] = 1'b1;
                        end else begin
                            nm++; m_mp[i] = 1'b1;
                        end
                    end
                end
                m_score = (m_score + nc > SMAX) ? SMAX : m_score + nc;
                m_lives = (m_lives - nm < 0) ? 0 : m_lives - nm;
                if (frame_tick) m_frame = (m_frame + 1) % 65536;
                if (m_lives == 0)  m_state = S_OVER;
                else if (pe)       m_state = S_PAUSE;
            end
            S_PAUSE: if (pe) m_state = S_PLAY;
            default: if (re) m_state = S_IDLE;
        endcase
        m_level = (m_score / 10 > 15) ? 15 : m_score / 10;
        m_run   = (m_state == S_PLAY);
    endtask

    task automatic compare_all();
        chk("state",       int'(state),       int'(m_state));
        chk("score",       int'(score),       m_score);
        chk("lives",       int'(lives),       m_lives);
        chk("level",       int'(level),       m_level);
        chk("catch_pulse", int'(catch_pulse), int'(m_cp));
        chk("miss_pulse",  int'(miss_pulse),  int'(m_mp));
        chk("drops_run",   int'(drops_run),   int'(m_run));
        chk("frame_cnt",   int'(frame_cnt),   m_frame);
    endtask

    // One clock: advance the model on the edge, compare just after it.
    task automatic cyc();
        @(posedge pclk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_drop(input int i, input int x);
        drop_x[i*PW +: PW] = PW'(x);
    endtask

    task automatic set_all(input int x);
        for (int i = 0; i < ND; i++) set_drop(i, x);
    endtask

    task automatic land_pulse(input logic [ND-1:0] mask);
        drop_land = mask; cyc();
        drop_land = '0;   cyc();
    endtask

    task automatic press(input int which);
        if (which == 0) start_btn = 1; else if (which == 1) pause_btn = 1; else restart_btn = 1;
        cyc();
        start_btn = 0; pause_btn = 0; restart_btn = 0;
        cyc();
    endtask

    initial begin
        rst = 0; frame_tick = 0; start_btn = 0; pause_btn = 0; restart_btn = 0;
        catcher_x = '0; drop_x = '0; drop_land = '0;
        model_reset();
        repeat (3) cyc();
        chk("rst_state", int'(state), 1);
        chk("rst_lives", int'(lives), 0);
        chk("rst_run",   int'(drops_run), 0);
        rst = 1;
        repeat (2) cyc();

        start_btn = 1; cyc();
        chk("start_state", int'(state), 3);
        chk("start_lives", int'(lives), 3);
        chk("start_score", int'(score), 0);
        chk("start_run",   int'(drops_run), 1);
        start_btn = 0; cyc();

        catcher_x = 12'd100; set_drop(0, 140);
        drop_land = 4'b0001; cyc();
        chk("catch_pulse0", int'(catch_pulse), 1);
        chk("catch_score",  int'(score), 1);
        cyc();
        chk("held_strobe", int'(catch_pulse), 0);
        drop_land = '0; cyc();

        frame_tick = 1; repeat (3) cyc(); frame_tick = 0; cyc();
        chk("frame_cnt3", int'(frame_cnt), 3);

        set_drop(0, 100); set_drop(1, 60); set_drop(2, 148); set_drop(3, 0);
        drop_land = 4'hF; cyc();
        chk("multi_catch", int'(catch_pulse), 4'b0011);
        chk("multi_miss",  int'(miss_pulse),  4'b1100);
        chk("multi_score", int'(score), 3);
        chk("multi_lives", int'(lives), 1);
        chk("multi_state", int'(state), 3);
        drop_land = '0; cyc();

        set_drop(0, 148); drop_land = 4'b0001; cyc();
        chk("edge_miss",  int'(miss_pulse), 1);
        chk("over_lives", int'(lives), 0);
        chk("over_state", int'(state), 2);
        drop_land = '0; cyc();
        set_drop(0, 100); land_pulse(4'b0001);
        chk("over_hold_score", int'(score), 3);

        restart_btn = 1; cyc();
        chk("restart_state", int'(state), 1);
        chk("restart_score", int'(score), 3);
        restart_btn = 0; cyc();

        press(0);
        set_all(100);
        land_pulse(4'hF); land_pulse(4'hF); land_pulse(4'b0001);
        chk("score9_level", int'(level), 0);
        drop_land = 4'b0011; cyc();
        chk("score11", int'(score), 11);
        chk("level1",  int'(level), 1);
        drop_land = '0; cyc();

        pause_btn = 1; cyc();
        chk("pause_state", int'(state), 0);
        chk("pause_run",   int'(drops_run), 0);
        pause_btn = 0; drop_land = 4'hF; frame_tick = 1; cyc(); cyc();
        chk("pause_score", int'(score), 11);
        chk("pause_frame", int'(frame_cnt), 0);
        drop_land = '0; frame_tick = 0; cyc();
        press(1);
        chk("unpause_state", int'(state), 3);

        drop_land = 4'b0001; pause_btn = 1; cyc();
        chk("landpause_score", int'(score), 12);
        chk("landpause_state", int'(state), 0);
        drop_land = '0; pause_btn = 0; cyc();
        press(1);

        set_drop(0, 148);
        land_pulse(4'b0001); land_pulse(4'b0001);
        chk("lives1", int'(lives), 1);
        drop_land = 4'b0001; pause_btn = 1; cyc();
        chk("fatal_pause_state", int'(state), 2);
        drop_land = '0; pause_btn = 0; cyc();

        press(2); press(0);
        set_all(100);
        land_pulse(4'hF); land_pulse(4'b0111);
        chk("score7", int'(score), 7);

        start_btn = 1; #2;
        rst = 0; model_reset(); #1;
        chk("async_state", int'(state), 1);
        chk("async_score", int'(score), 0);
        chk("async_run",   int'(drops_run), 0);
        compare_all();
        cyc(); cyc();
        rst = 1;
        repeat (3) cyc();
        chk("held_start_state", int'(state), 1);
        start_btn = 0; cyc();
        press(0);
        chk("repress_state", int'(state), 3);

        set_all(100);
        repeat (16383) land_pulse(4'hF);
        chk("score65532", int'(score), 65532);
        chk("level_sat",  int'(level), 15);
        land_pulse(4'b0011);
        chk("score65534", int'(score), 65534);
        drop_land = 4'b0111; cyc();
        chk("score_sat", int'(score), 65535);
        chk("sat_pulse", int'(catch_pulse), 4'b0111);
        drop_land = '0; cyc();
        land_pulse(4'b0001);
        chk("score_sat_hold", int'(score), 65535);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
